// File: rtl/nv_fifo_rws_pkg.sv
// nv_fifo_rws_pkg
//   Shared constants for the valid/ready FIFO controller that sits in front of
//   a two-port RAM with a registered read address.
//   DEF_DEPTH/DEF_AW/DEF_DW : default RAM geometry (entries, address bits, data bits)
//   PTR_W/CNT_W             : pointer width and RAM occupancy counter width
//   OBUF_DEPTH/OCC_W        : output register FIFO depth and its occupancy width
package nv_fifo_rws_pkg;
   localparam int DEF_DEPTH  = 128;
   localparam int DEF_AW     = 7;
   localparam int DEF_DW     = 128;
   localparam int PTR_W      = DEF_AW;
   localparam int CNT_W      = DEF_AW + 1;
   localparam int OBUF_DEPTH = 2;
   localparam int OCC_W      = 2;
endpackage

// File: rtl/nv_fifo_rws_ctrl_obuf.sv
// nv_fifo_rws_obuf
//   Two-entry register FIFO that presents RAM read data (or bypassed payloads)
//   as a registered valid/ready stream. head is the oldest entry and never
//   changes while it is valid and not popped.
//   clk_sys  in   clock
//   rst_b    in   async active-low reset
//   push     in   write din (caller guarantees room after this cycle's pop)
//   din      in   DW data
//   pop      in   remove head (only while vld)
//   occ      out  number of held entries (0..2)
//   vld      out  registered occ != 0
//   head     out  oldest entry
module nv_fifo_rws_obuf
   import nv_fifo_rws_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             push,
   input  logic [DW-1:0]    din,
   input  logic             pop,
   output logic [OCC_W-1:0] occ,
   output logic             vld,
   output logic [DW-1:0]    head
);
   logic [DW-1:0]    tail;
   logic [OCC_W-1:0] occ_next;

   always_comb begin
      occ_next = occ;
      if (push && !pop)
         occ_next = occ + 1'b1;
      else if (pop && !push)
         occ_next = occ - 1'b1;
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         occ  <= '0;
         vld  <= 1'b0;
         head <= '0;
         tail <= '0;
      end else begin
         occ <= occ_next;
         vld <= (occ_next != '0);
         if (occ == OCC_W'(0)) begin
            if (push)
               head <= din;
         end else if (occ == OCC_W'(1)) begin
            // with a pop the new word becomes head directly, otherwise it queues behind
            if (push && pop)
               head <= din;
            else if (push)
               tail <= din;
         end else begin
            if (pop) begin
               head <= tail;
               if (push)
                  tail <= din;
            end
         end
      end
   end
endmodule

// File: rtl/nv_fifo_rws_ctrl.sv
// nv_fifo_rws_ctrl
//   Valid/ready FIFO controller owning both ports of a DEPTH x DW two-port RAM
//   with registered read address. Writes go to the RAM, reads are issued so
//   that the two-entry output buffer can never overflow, and read data is
//   captured the cycle after ram_re.
//   Optional feature macro: NV_FIFO_RWS_BYPASS_EN -- a write arriving while
//   nothing is queued in the RAM path goes straight into the output buffer.
//   Ports:
//     nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//     wr_pvld/wr_prdy/wr_pd            : producer stream (wr_prdy registered)
//     rd_pvld/rd_prdy/rd_pd            : consumer stream (registered outputs)
//     ram_we/ram_wa/ram_di             : RAM write port
//     ram_re/ram_ra/ram_dout           : RAM read port, data one cycle after ram_re
module nv_fifo_rws_ctrl
   import nv_fifo_rws_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW
) (
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rstn,
   input  logic          wr_pvld,
   output logic          wr_prdy,
   input  logic [DW-1:0] wr_pd,
   output logic          rd_pvld,
   input  logic          rd_prdy,
   output logic [DW-1:0] rd_pd,
   output logic          ram_we,
   output logic [AW-1:0] ram_wa,
   output logic [DW-1:0] ram_di,
   output logic          ram_re,
   output logic [AW-1:0] ram_ra,
   input  logic [DW-1:0] ram_dout
);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [CW-1:0]    ram_cnt;
   logic [CW-1:0]    ram_cnt_next;
   logic             inflight;
   logic [OCC_W-1:0] occ;
   logic [2:0]       obuf_load;
   logic             wr_acc;
   logic             pop;
   logic             issue;
   logic             capture;
   logic             bypass;
   logic             to_ram;
   logic             push;
   logic [DW-1:0]    push_data;

   assign wr_acc  = wr_pvld & wr_prdy;
   assign pop     = rd_pvld & rd_prdy;
   assign capture = inflight;

`ifdef NV_FIFO_RWS_BYPASS_EN
   // nothing older sits in RAM or in flight, so going straight to obuf keeps order
   assign bypass = wr_acc && (ram_cnt == '0) && !inflight &&
                   (({1'b0, occ} - {2'b00, pop}) < 3'(OBUF_DEPTH));
`else
   assign bypass = 1'b0;
`endif

   assign to_ram    = wr_acc & ~bypass;
   assign push      = capture | bypass;
   assign push_data = bypass ? wr_pd : ram_dout;

   // an outstanding read already owns one obuf slot
   assign obuf_load = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign issue     = ((ram_cnt - CW'(inflight)) != '0) && (obuf_load < 3'(OBUF_DEPTH));

   // entries stay counted until captured so a latched read address is never rewritten
   assign ram_cnt_next = ram_cnt + CW'(to_ram) - CW'(capture);

   assign ram_we = to_ram;
   assign ram_wa = wptr;
   assign ram_di = wr_pd;
   assign ram_re = issue;
   assign ram_ra = rptr;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         wr_prdy  <= 1'b0;
      end else begin
         if (to_ram)
            wptr <= wptr + 1'b1;
         if (issue)
            rptr <= rptr + 1'b1;
         inflight <= issue;
         ram_cnt  <= ram_cnt_next;
         wr_prdy  <= (ram_cnt_next < CW'(DEPTH));
      end
   end

   nv_fifo_rws_obuf #(
      .DW (DW)
   ) u_obuf (
      .clk_sys (nvdla_core_clk),
      .rst_b   (nvdla_core_rstn),
      .push    (push),
      .din     (push_data),
      .pop     (pop),
      .occ     (occ),
      .vld     (rd_pvld),
      .head    (rd_pd)
   );
endmodule

// File: tb/tb_nv_fifo_rws_ctrl.sv
module tb_nv_fifo_rws_ctrl;
   import nv_fifo_rws_pkg::*;
   localparam int DEPTH = DEF_DEPTH;
   localparam int AW    = DEF_AW;
   localparam int DW    = DEF_DW;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_pvld = 1'b0;
   logic          wr_prdy;
   logic [DW-1:0] wr_pd = '0;
   logic          rd_pvld;
   logic          rd_prdy = 1'b0;
   logic [DW-1:0] rd_pd;
   logic          ram_we;
   logic [AW-1:0] ram_wa;
   logic [DW-1:0] ram_di;
   logic          ram_re;
   logic [AW-1:0] ram_ra;
   logic [DW-1:0] ram_dout;
   logic [DW-1:0] mem [DEPTH];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   nv_fifo_rws_ctrl dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .wr_pvld         (wr_pvld),
      .wr_prdy         (wr_prdy),
      .wr_pd           (wr_pd),
      .rd_pvld         (rd_pvld),
      .rd_prdy         (rd_prdy),
      .rd_pd           (rd_pd),
      .ram_we          (ram_we),
      .ram_wa          (ram_wa),
      .ram_di          (ram_di),
      .ram_re          (ram_re),
      .ram_ra          (ram_ra),
      .ram_dout        (ram_dout)
   );

   // two-port RAM, read address registered on ram_re
   always @(posedge clk) begin
      if (ram_we) mem[ram_wa] <= ram_di;
      if (ram_re) ram_dout <= mem[ram_ra];
   end

   task automatic check_b(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b required %0b", nm, act, exp);
      end
   endtask

   task automatic check_i(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic check_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int n);
      return {4{n}};
   endfunction

   // scoreboard / protocol monitor, samples mid-cycle
   logic [DW-1:0] sb_q [$];
   logic          busy [DEPTH];
   logic          prev_re = 1'b0;
   logic [AW-1:0] prev_ra = '0;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] stall_pd = '0;
   bit            acc_s = 1'b0;
   int            n_acc = 0;
   int            n_pop = 0;
   int            cyc = 0;
   int            last_pop_cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         sb_q.delete();
         for (int i = 0; i < DEPTH; i++) busy[i] = 1'b0;
         prev_re    = 1'b0;
         stall_prev = 1'b0;
         acc_s      = 1'b0;
      end else begin
         if (stall_prev) begin
            check_b("stall_vld", rd_pvld, 1'b1);
            check_d("stall_pd", rd_pd, stall_pd);
         end
         if (prev_re) busy[prev_ra] = 1'b0;
         if (ram_we) begin
            check_b("wr_to_free_slot", busy[ram_wa], 1'b0);
            busy[ram_wa] = 1'b1;
         end
         if (ram_re) check_b("rd_of_live_slot", busy[ram_ra], 1'b1);
         prev_re = ram_re;
         prev_ra = ram_ra;
         acc_s = wr_pvld && wr_prdy;
         if (acc_s) begin
            sb_q.push_back(wr_pd);
            n_acc++;
         end
         if (rd_pvld && rd_prdy) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_pop: got word %h, required none outstanding", rd_pd);
            end else if (rd_pd !== sb_q[0]) begin
               errors++;
               $display("FAIL sb_data: got %h required %h", rd_pd, sb_q[0]);
               void'(sb_q.pop_front());
            end else begin
               void'(sb_q.pop_front());
            end
            n_pop++;
            last_pop_cyc = cyc;
         end
         stall_prev = rd_pvld && !rd_prdy;
         stall_pd   = rd_pd;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn    = 1'b0;
      wr_pvld = 1'b0;
      rd_prdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic drain(input string nm);
      int w;
      w = 0;
      wr_pvld = 1'b0;
      rd_prdy = 1'b1;
      while ((sb_q.size() != 0 || rd_pvld) && w < 500) begin
         tick();
         w++;
      end
      check_i(nm, sb_q.size(), 0);
      check_b({nm, "_vld"}, rd_pvld, 1'b0);
      rd_prdy = 1'b0;
   endtask

   typedef struct packed {
      bit wv;
      bit rr;
      bit e_prdy;
      bit e_vld;
      bit e_we;
      bit e_re;
   } vec_t;

   vec_t tv [7];

   initial begin
      int a0, p0, w, cf;
      bit started;

      // ---------------- single write latency table
      tv[0] = 6'b00_0000;
`ifdef NV_FIFO_RWS_BYPASS_EN
      tv[1] = 6'b10_1000;
      tv[2] = 6'b00_1100;
      tv[3] = 6'b00_1100;
      tv[4] = 6'b00_1100;
      tv[5] = 6'b01_1100;
      tv[6] = 6'b00_1000;
`else
      tv[1] = 6'b10_1010;
      tv[2] = 6'b00_1001;
      tv[3] = 6'b00_1000;
      tv[4] = 6'b00_1100;
      tv[5] = 6'b01_1100;
      tv[6] = 6'b00_1000;
`endif
      do_reset();
      for (int i = 0; i < 7; i++) begin
         if (i != 0) tick();
         wr_pvld = tv[i].wv;
         rd_prdy = tv[i].rr;
         wr_pd   = {16{8'hA5}};
         @(negedge clk);
         check_b($sformatf("t1_wr_prdy[%0d]", i), wr_prdy, tv[i].e_prdy);
         check_b($sformatf("t1_rd_pvld[%0d]", i), rd_pvld, tv[i].e_vld);
         check_b($sformatf("t1_ram_we[%0d]", i), ram_we, tv[i].e_we);
         check_b($sformatf("t1_ram_re[%0d]", i), ram_re, tv[i].e_re);
         if (i == 0) check_d("t1_reset_rd_pd", rd_pd, '0);
      end
      tick();
      rd_prdy = 1'b0;
      check_i("t1_sb_empty", sb_q.size(), 0);
      check_i("t1_ram_cnt", int'(dut.ram_cnt), 0);

      // ---------------- fill with consumer stalled
      do_reset();
      tick();
      a0 = n_acc;
      for (int i = 0; i < 150; i++) begin
         wr_pvld = 1'b1;
         wr_pd   = pat(n_acc);
         @(negedge clk);
         tick();
      end
      wr_pd = pat(n_acc);
      check_i("fill_accepts", n_acc - a0, 130);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_b("fill_prdy_low", wr_prdy, 1'b0);
         check_b("fill_no_we", ram_we, 1'b0);
         tick();
      end
      rd_prdy = 1'b1;
      @(negedge clk);
      tick();
      rd_prdy = 1'b0;
      w = 0;
      while (n_acc - a0 < 131 && w < 10) begin
         @(negedge clk);
         tick();
         w++;
      end
      wr_pvld = 1'b0;
      check_i("fill_held_accepted", n_acc - a0, 131);
      drain("fill_drain");

      // ---------------- continuous stream, both sides ready
      do_reset();
      tick();
      a0 = n_acc;
      p0 = n_pop;
      w = 0;
      cf = 0;
      started = 1'b0;
      while ((n_pop - p0 < 1000) && w < 1500) begin
         wr_pvld = (n_acc - a0) < 1000;
         wr_pd   = pat(n_acc);
         rd_prdy = 1'b1;
         @(negedge clk);
         tick();
         if (!started && (n_pop - p0) >= 1) begin
            started = 1'b1;
            cf = last_pop_cyc;
         end
         w++;
      end
      wr_pvld = 1'b0;
      check_i("stream_count", n_pop - p0, 1000);
      check_i("stream_rate", last_pop_cyc - cf, 999);
      drain("stream_drain");

      // ---------------- random valid/ready
      do_reset();
      tick();
      a0 = n_acc;
      p0 = n_pop;
      w = 0;
      while ((n_pop - p0 < 10000) && w < 40000) begin
         wr_pvld = ((n_acc - a0) < 10000) && ($urandom_range(0, 1) == 1);
         wr_pd   = pat(n_acc);
         rd_prdy = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         tick();
         w++;
      end
      wr_pvld = 1'b0;
      check_i("random_count", n_pop - p0, 10000);
      drain("random_drain");

      // ---------------- reset with entries in flight
      do_reset();
      tick();
      a0 = n_acc;
      w = 0;
      while (n_acc - a0 < 40 && w < 100) begin
         wr_pvld = 1'b1;
         wr_pd   = pat(n_acc);
         @(negedge clk);
         tick();
         w++;
      end
      check_i("rst_prefill", n_acc - a0, 40);
      wr_pd = pat(n_acc);
      check_b("rst_pre_vld", rd_pvld, 1'b1);
      rstn = 1'b0;
      #1;
      check_b("rst_wr_prdy", wr_prdy, 1'b0);
      check_b("rst_rd_pvld", rd_pvld, 1'b0);
      check_d("rst_rd_pd", rd_pd, '0);
      check_b("rst_ram_we", ram_we, 1'b0);
      check_b("rst_ram_re", ram_re, 1'b0);
      check_i("rst_ram_wa", int'(ram_wa), 0);
      check_i("rst_ram_ra", int'(ram_ra), 0);
      wr_pvld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      tick();
      wr_pvld = 1'b1;
      wr_pd   = {{(DW-1){1'b0}}, 1'b1};
      @(negedge clk);
      tick();
      wr_pvld = 1'b0;
      p0 = n_pop;
      drain("rst_drain");
      check_i("rst_single_pop", n_pop - p0, 1);

      // ---------------- write accept + capture + pop in one cycle
      do_reset();
      tick();
      for (int i = 0; i < 4; i++) begin
         wr_pvld = 1'b1;
         wr_pd   = pat(n_acc);
         @(negedge clk);
         tick();
      end
      wr_pvld = 1'b0;
      repeat (6) tick();
      @(negedge clk);
      check_i("sim_pre_cnt", int'(dut.ram_cnt), 2);
      check_i("sim_pre_occ", int'(dut.u_obuf.occ), 2);
      tick();
      wr_pvld = 1'b1;
      wr_pd   = pat(n_acc);
      rd_prdy = 1'b1;
      @(negedge clk);
      check_b("sim_a_issue", ram_re, 1'b1);
      tick();
      wr_pd = pat(n_acc);
      @(negedge clk);
      check_b("sim_b_capture", dut.inflight, 1'b1);
      check_b("sim_b_we", ram_we, 1'b1);
      check_b("sim_b_pop", rd_pvld, 1'b1);
      check_i("sim_b_cnt", int'(dut.ram_cnt), 3);
      check_i("sim_b_occ", int'(dut.u_obuf.occ), 1);
      tick();
      wr_pvld = 1'b0;
      rd_prdy = 1'b0;
      @(negedge clk);
      check_i("sim_c_cnt", int'(dut.ram_cnt), 3);
      check_i("sim_c_occ", int'(dut.u_obuf.occ), 1);
      tick();
      drain("sim_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/nv_fifo_rws_ctrl.md
# nv_fifo_rws_ctrl

Valid/ready FIFO controller that drives a 128-entry x 128-bit two-port RAM with a registered read address. It owns both RAM ports: it writes incoming payloads and issues reads, and it captures read data into a two-entry output buffer so consumers see a plain valid/ready stream. It sits between a producer and consumer inside an NVDLA sub-unit, with the RAM macro instantiated alongside it by the parent.

## Interface
- DEPTH, 128, RAM entries; must be a power of two.
- AW, 7, RAM address width, log2(DEPTH).
- DW, 128, payload and RAM data width.

Ports:
- nvdla_core_clk  in  1  single clock.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- wr_pvld  in  1  producer valid.
- wr_prdy  out  1  producer ready; registered.
- wr_pd  in  DW  producer payload.
- rd_pvld  out  1  consumer valid; registered.
- rd_prdy  in  1  consumer ready.
- rd_pd  out  DW  consumer payload; registered.
- ram_we  out  1  RAM write enable.
- ram_wa  out  AW  RAM write address.
- ram_di  out  DW  RAM write data.
- ram_re  out  1  RAM read enable; the RAM latches ram_ra on this edge.
- ram_ra  out  AW  RAM read address.
- ram_dout  in  DW  RAM data for the address latched by the last ram_re.

## Operation
- Write accept: wr_pvld & wr_prdy. Same cycle: ram_we=1, ram_wa=wptr, ram_di=wr_pd. Then wptr++ (wraps 127->0) and ram_cnt++.
- ram_cnt (0..DEPTH, AW+1 bits) counts RAM-resident entries not yet captured.
- wr_prdy <= (ram_cnt_next < DEPTH).
- Read issue condition: (ram_cnt - inflight) > 0 and (obuf_occ + inflight - pop) < 2, where pop = rd_pvld & rd_prdy.
- Read issue: ram_re=1, ram_ra=rptr. Then rptr++ (wraps) and inflight<=1.
- Capture: the cycle after an issue (inflight=1), ram_dout is pushed into obuf and ram_cnt--. An entry is freed only at capture, so its address cannot be rewritten while it is latched in the RAM.
- obuf: 2-entry register FIFO. rd_pd is the head, rd_pvld = obuf_occ != 0.
- Simultaneous write accept and capture: ram_cnt is unchanged.
- Simultaneous pop and capture: occupancy is unchanged and order is preserved.
- ram_re and ram_we may assert in the same cycle. Addresses never collide because of the ram_cnt accounting.
- When the FIFO is full (ram_cnt=DEPTH), wr_prdy=0. A producer holding wr_pvld sees no accept; wr_pd must stay stable.
- When empty, no ram_re is issued and rd_pvld=0.

## Timing
- Reset values: wr_prdy=0 (it goes to 1 on the first clock after deassertion), rd_pvld=0, rd_pd=0, ram_we=0, ram_re=0, ram_wa=ram_ra=0, and all pointers and counts 0.
- Reset mid-operation discards all contents immediately (asynchronous). No RAM scrubbing is performed.
- Latency, write accepted at cycle T into an empty FIFO: ram_re at T+1, capture at T+2, rd_pvld=1 at T+3.
- Throughput: 1 payload/cycle sustained once primed, with rd_prdy held high.
- rd_pvld/rd_pd hold while rd_prdy=0. Once valid, rd_pd never changes until popped.

## Configuration
- NV_FIFO_RWS_BYPASS_EN defined:
  - A write accepted when ram_cnt=0, inflight=0 and obuf has room after this cycle's pop goes straight into obuf.
  - In that case there is no RAM write and no ram_cnt change, and empty-FIFO latency becomes 1 (rd_pvld at T+1).
  - Ordering is preserved because bypass only occurs when nothing is older in the RAM path.
- Undefined: every payload traverses the RAM; latency is 3.

## Structure
- Shared package: DEPTH/AW/DW defaults, the pointer/count widths, and the obuf depth constant (2).
- One natural sub-module, nv_fifo_rws_obuf: the 2-entry output register FIFO with push/pop/occ.
- Pointer, count and issue logic stay in the top.

## Test plan
- Reset then a single write of 0xA5..A5: wr_prdy rises one cycle after reset release. The data appears on rd_pd with rd_pvld at T+3 (T+1 with bypass) and pops cleanly; ram_cnt returns to 0.
- Fill 128 writes with rd_prdy=0: obuf holds 2 and the RAM holds 128, so wr_prdy drops after 130 accepts. A 131st write is held, then accepted once a pop frees space.
- Continuous stream of 1000 incrementing words with both sides always ready: output is in order, 1 word/cycle after priming, and wptr/rptr wrap cleanly.
- Random wr_pvld/rd_prdy (50%) for 10k words: scoreboard matches, rd_pd is stable while stalled, and ram_ra never equals an unfreed ram_wa.
- Assert reset with 40 entries in flight: all outputs are at reset values immediately. After release, new data 0x1 emerges first with no stale entries.
- Simultaneous write accept, capture and pop in one cycle: ram_cnt and obuf_occ are unchanged and order is preserved.
